// File: rtl/regfile_32x32_if.sv
// Register-file access bus: one write port and two combinational read ports.
// The datapath drives addresses and write data; the register file returns read data.
interface regfile_32x32_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile_32x32.sv
// 32x32 general-purpose register file: r0 reads as zero, two combinational
// read ports with same-cycle write forwarding, one synchronous write port.
module regfile_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  regfile_32x32_if.slave   rf
);
  localparam int NRD = 2;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [NRD-1:0][ADDR_W-1:0]   raddr;
  logic [NRD-1:0][DATA_W-1:0]   rdata;

  assign raddr = {rf.raddr2, rf.raddr1};

  // r0 is cleared by reset and never written, so it folds to a constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      regs <= '0;
    else if (rf.we && (rf.waddr != '0))
      regs[rf.waddr] <= rf.wdata;
  end

  // A read of the register being written this cycle sees the incoming data.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    always_comb begin
      rdata[p] = '0;
      if (!rst && (raddr[p] != '0))
        rdata[p] = (rf.we && (rf.waddr == raddr[p])) ? rf.wdata : regs[raddr[p]];
    end
  end

  assign rf.rdata1 = rdata[0];
  assign rf.rdata2 = rdata[1];
endmodule

// File: tb/tb_regfile_32x32.sv
// Randomized bench for regfile_32x32 against an array-based model, plus
// directed literal checks for reset, r0, forwarding, aliasing and reset-mid-write.
module tb_regfile_32x32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  logic [31:0] mem [32];

  regfile_32x32_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_32x32 dut (.clk(clk), .rst(rst), .rf(bus));

  always #5 clk = ~clk;

  // Reference state: a plain array, cleared whenever reset is seen.
  initial foreach (mem[i]) mem[i] = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (mem[i]) mem[i] = '0;
    end else if (bus.we === 1'b1 && bus.waddr != 5'd0) begin
      mem[bus.waddr] = bus.wdata;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst)            return 32'd0;
    if (a == 5'd0)      return 32'd0;
    if (bus.we && bus.waddr == a) return bus.wdata;
    return mem[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rdata1", bus.rdata1, exp_rd(bus.raddr1));
      check("cmp_rdata2", bus.rdata2, exp_rd(bus.raddr2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr1 = '0; bus.raddr2 = '0;
    repeat (3) step();
    // Reset state during reset
    bus.raddr1 = 5'd7; bus.raddr2 = 5'd31;
    #1;
    check("reset_hold_rd1", bus.rdata1, 32'd0);
    check("reset_hold_rd2", bus.rdata2, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: sweep all addresses after reset
    for (int i = 0; i < 32; i++) begin
      bus.raddr1 = 5'(i); bus.raddr2 = 5'(31 - i);
      #1;
      check("sweep_rd1", bus.rdata1, 32'd0);
      check("sweep_rd2", bus.rdata2, 32'd0);
    end

    // 2: basic write then read
    step();
    bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'd20;
    step();
    bus.we = 1'b0; bus.raddr1 = 5'd10; bus.raddr2 = 5'd20;
    #1;
    check("wr_r10", bus.rdata1, 32'd20);
    check("rd_r20_zero", bus.rdata2, 32'd0);

    // 3: r0 writes discarded
    step();
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF; bus.raddr1 = 5'd0;
    #1;
    check("r0_during", bus.rdata1, 32'd0);
    step();
    bus.we = 1'b0;
    #1;
    check("r0_after", bus.rdata1, 32'd0);

    // 4: same-cycle forwarding on both ports
    step();
    bus.we = 1'b1; bus.waddr = 5'd20; bus.wdata = 32'd10; bus.raddr1 = 5'd20; bus.raddr2 = 5'd20;
    #1;
    check("byp_rd1", bus.rdata1, 32'd10);
    check("byp_rd2", bus.rdata2, 32'd10);
    step();
    bus.we = 1'b0;
    #1;
    check("byp_after_rd1", bus.rdata1, 32'd10);
    check("byp_after_rd2", bus.rdata2, 32'd10);

    // 5: extreme addresses and aliasing
    step();
    bus.we = 1'b1; bus.waddr = 5'd31; bus.wdata = 32'hDEAD_BEEF;
    step();
    bus.waddr = 5'd1; bus.wdata = 32'h1;
    step();
    bus.we = 1'b0; bus.raddr1 = 5'd31; bus.raddr2 = 5'd1;
    #1;
    check("r31", bus.rdata1, 32'hDEAD_BEEF);
    check("r1", bus.rdata2, 32'h1);
    bus.raddr1 = 5'd30; bus.raddr2 = 5'd2;
    #1;
    check("r30_zero", bus.rdata1, 32'd0);
    check("r2_zero", bus.rdata2, 32'd0);

    // 6: async reset during a write to r10
    step();
    bus.raddr1 = 5'd10;
    #1;
    check("r10_before", bus.rdata1, 32'd20);
    step();
    bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'd7;
    #1;
    check("r10_byp7", bus.rdata1, 32'd7);
    rst = 1'b1;
    #1;
    check("r10_async_clr", bus.rdata1, 32'd0);
    step();
    rst = 1'b0; bus.we = 1'b0;
    #1;
    check("r10_write_lost", bus.rdata1, 32'd0);

    // Randomized traffic; the compare process checks each cycle.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      bus.we     = $urandom_range(0, 1);
      bus.waddr  = 5'($urandom);
      bus.wdata  = $urandom;
      bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom);
      bus.raddr2 = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom);
    end
    step();
    rst = 1'b0; bus.we = 1'b0;
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
